// File: rtl/spi_cmd_ctrl_if.sv
// Connection bundle between spi_cmd_ctrl, the SPI byte client and the register bus.
// The master modport is the sequencer's view; the slave modport is the surrounding logic's view.
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              i_active;
  logic              i_rx_valid;
  logic              i_rx_start;
  logic [7:0]        i_rx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic [7:0]        o_tx_data;
  logic [ADDR_W-1:0] o_bus_addr;
  logic              o_bus_wen;
  logic [7:0]        o_bus_wdata;
  logic              o_bus_ren;
  logic [7:0]        i_bus_rdata;
  logic              i_bus_rvalid;
  logic              o_err;

  modport master (
    input  i_active, i_rx_valid, i_rx_start, i_rx_data, i_tx_ready, i_bus_rdata, i_bus_rvalid,
    output o_tx_valid, o_tx_data, o_bus_addr, o_bus_wen, o_bus_wdata, o_bus_ren, o_err
  );

  modport slave (
    output i_active, i_rx_valid, i_rx_start, i_rx_data, i_tx_ready, i_bus_rdata, i_bus_rvalid,
    input  o_tx_valid, o_tx_data, o_bus_addr, o_bus_wen, o_bus_wdata, o_bus_ren, o_err
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: decodes host bytes (cmd, addr, data...), drives the single-master register
// bus and returns read/status bytes to the SPI client. All outputs are registered.
module spi_cmd_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic           i_clock,
  input  logic           i_reset,
  spi_cmd_ctrl_if.master bus_if
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_WDATA   = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD_TX   = 3'd5;
  localparam logic [2:0] ST_DRAIN   = 3'd6;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [2:0]        state_q,    state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        wdata_q,    wdata_d;
  logic              wen_q,      wen_d;
  logic              ren_q,      ren_d;
  logic              err_q,      err_d;
  logic              is_read_q,  is_read_d;
  logic [TMO_W-1:0]  tmo_q,      tmo_d;

  logic rx_byte_s;
  logic rx_cmd_s;

  assign rx_byte_s = bus_if.i_rx_valid;
  assign rx_cmd_s  = bus_if.i_rx_valid & bus_if.i_rx_start;

  // next-state: CS loss dominates, then a start byte resyncs, then the per-state sequencing
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    err_d      = err_q;
    is_read_d  = is_read_q;
    tmo_d      = tmo_q;

    if (!bus_if.i_active) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end else if (rx_cmd_s) begin
      tx_valid_d = 1'b0;
      case (bus_if.i_rx_data)
        CMD_WRITE: begin
          is_read_d = 1'b0;
          state_d   = ST_ADDR;
        end
        CMD_READ: begin
          is_read_d = 1'b1;
          state_d   = ST_ADDR;
        end
        CMD_STATUS: begin
          tx_data_d  = {7'b0000000, err_q};
          tx_valid_d = 1'b1;
          err_d      = 1'b0;
          state_d    = ST_DRAIN;
        end
        default: begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ADDR: begin
          if (rx_byte_s) begin
            addr_d  = ADDR_W'(bus_if.i_rx_data);
            state_d = is_read_q ? ST_RD_REQ : ST_WDATA;
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_WDATA: begin
          // address advances on the cycle the strobe is visible, ready for the next byte
          if (wen_q) begin
            addr_d = addr_q + ADDR_ONE;
          end else begin
            addr_d = addr_q;
          end
          if (rx_byte_s) begin
            wdata_d = bus_if.i_rx_data;
            wen_d   = 1'b1;
          end else begin
            wen_d   = 1'b0;
          end
        end
        ST_RD_REQ: begin
          ren_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (bus_if.i_bus_rvalid) begin
            tx_data_d  = bus_if.i_bus_rdata;
            tx_valid_d = 1'b1;
            state_d    = ST_RD_TX;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
        ST_RD_TX: begin
          if (bus_if.i_tx_ready) begin
            tx_valid_d = 1'b0;
            addr_d     = addr_q + ADDR_ONE;
            state_d    = ST_RD_REQ;
          end else begin
            state_d = ST_RD_TX;
          end
        end
        ST_DRAIN: begin
          if (bus_if.i_tx_ready) begin
            tx_valid_d = 1'b0;
          end else begin
            tx_valid_d = tx_valid_q;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      endcase
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      err_q      <= 1'b0;
      is_read_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      err_q      <= err_d;
      is_read_q  <= is_read_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus_if.o_tx_valid  = tx_valid_q;
  assign bus_if.o_tx_data   = tx_data_q;
  assign bus_if.o_bus_addr  = addr_q;
  assign bus_if.o_bus_wen   = wen_q;
  assign bus_if.o_bus_wdata = wdata_q;
  assign bus_if.o_bus_ren   = ren_q;
  assign bus_if.o_err       = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: write burst, wrapping read burst, bad cmd/status,
// read timeout, CS abort mid-write and reset during a pending read.
module tb_spi_cmd_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  spi_cmd_ctrl_if #(.ADDR_W(8)) bif ();

  spi_cmd_ctrl #(.ADDR_W(8), .RD_TIMEOUT(15)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus_if  (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] wen_addr_q [$];
  logic [7:0] wen_data_q [$];
  logic [7:0] ren_addr_q [$];
  int         wen_cnt;
  int         ren_cnt;
  int         wen_run;
  int         wen_run_max;
  int         both_cnt;
  bit         resp_en;
  int         resp_lat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // strobe monitor, sampled on the inactive edge
  initial begin
    wen_cnt = 0; wen_run = 0; wen_run_max = 0; both_cnt = 0;
    forever begin
      @(negedge clk);
      if (bif.o_bus_wen === 1'b1) begin
        wen_cnt++;
        wen_run++;
        if (wen_run > wen_run_max) wen_run_max = wen_run;
        wen_addr_q.push_back(bif.o_bus_addr);
        wen_data_q.push_back(bif.o_bus_wdata);
      end else begin
        wen_run = 0;
      end
      if (bif.o_bus_wen === 1'b1 && bif.o_bus_ren === 1'b1) both_cnt++;
    end
  end

  // register-file read responder with programmable latency
  initial begin
    logic [7:0] a;
    ren_cnt = 0;
    bif.i_bus_rvalid = 1'b0;
    bif.i_bus_rdata  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bif.o_bus_ren === 1'b1) begin
        ren_cnt++;
        ren_addr_q.push_back(bif.o_bus_addr);
        if (resp_en) begin
          a = bif.o_bus_addr;
          repeat (resp_lat) @(posedge clk);
          #1;
          bif.i_bus_rvalid = 1'b1;
          bif.i_bus_rdata  = mem[a];
          @(posedge clk);
          #1;
          bif.i_bus_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic st);
    @(negedge clk);
    bif.i_rx_valid = 1'b1;
    bif.i_rx_start = st;
    bif.i_rx_data  = d;
    @(negedge clk);
    bif.i_rx_valid = 1'b0;
    bif.i_rx_start = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (bif.o_tx_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bif.o_tx_valid), 32'd1);
    check_eq(tag, 32'(bif.o_tx_data), 32'(exp));
  endtask

  task automatic ack_tx();
    bif.i_tx_ready = 1'b1;
    @(negedge clk);
    bif.i_tx_ready = 1'b0;
  endtask

  task automatic wait_ren(input string tag);
    int n;
    n = 0;
    while (bif.o_bus_ren !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(bif.o_bus_ren), 32'd1);
  endtask

  task automatic end_cs();
    @(negedge clk);
    bif.i_active = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int w0;
    int r0;
    n_cmp = 0; n_bad = 0;
    resp_en = 1'b1; resp_lat = 3;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B; mem[8'h00] = 8'h7C;
    rst = 1'b1;
    bif.i_active = 1'b0; bif.i_rx_valid = 1'b0; bif.i_rx_start = 1'b0;
    bif.i_rx_data = 8'h00; bif.i_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_valid", 32'(bif.o_tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(bif.o_tx_data), 32'd0);
    check_eq("rst_addr", 32'(bif.o_bus_addr), 32'd0);
    check_eq("rst_wdata", 32'(bif.o_bus_wdata), 32'd0);
    check_eq("rst_wen_ren", 32'({bif.o_bus_wen, bif.o_bus_ren}), 32'd0);
    check_eq("rst_err", 32'(bif.o_err), 32'd0);
    rst = 1'b0;

    // write burst
    bif.i_active = 1'b1;
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("wr_count", 32'(wen_cnt), 32'd2);
    if (wen_cnt >= 2) begin
      check_eq("wr0_addr", 32'(wen_addr_q[0]), 32'h10);
      check_eq("wr0_data", 32'(wen_data_q[0]), 32'hAA);
      check_eq("wr1_addr", 32'(wen_addr_q[1]), 32'h11);
      check_eq("wr1_data", 32'(wen_data_q[1]), 32'hBB);
    end
    check_eq("wr_pulse_width", 32'(wen_run_max), 32'd1);
    end_cs();

    // read burst wrapping past 0xFF
    bif.i_active = 1'b1;
    r0 = ren_cnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_tx("rd0", 8'h5A); ack_tx();
    wait_tx("rd1", 8'h6B); ack_tx();
    wait_tx("rd2", 8'h7C); ack_tx();
    check_eq("rd_ren_count", 32'(ren_cnt - r0 >= 3), 32'd1);
    if (ren_addr_q.size() >= r0 + 3) begin
      check_eq("rd_ren_addr0", 32'(ren_addr_q[r0]), 32'hFE);
      check_eq("rd_ren_addr1", 32'(ren_addr_q[r0 + 1]), 32'hFF);
      check_eq("rd_ren_addr2", 32'(ren_addr_q[r0 + 2]), 32'h00);
    end
    end_cs();

    // bad command then two STATUS reads
    bif.i_active = 1'b1;
    w0 = wen_cnt; r0 = ren_cnt;
    send_byte(8'h77, 1'b1);
    check_eq("bad_err", 32'(bif.o_err), 32'd1);
    check_eq("bad_state", 32'(dut.state_q), 32'd6);
    send_byte(8'h05, 1'b1);
    check_eq("st1_valid", 32'(bif.o_tx_valid), 32'd1);
    check_eq("st1_data", 32'(bif.o_tx_data), 32'h01);
    check_eq("st1_err_clr", 32'(bif.o_err), 32'd0);
    ack_tx();
    check_eq("st1_drained", 32'(bif.o_tx_valid), 32'd0);
    send_byte(8'h05, 1'b1);
    check_eq("st2_data", 32'(bif.o_tx_data), 32'h00);
    ack_tx();
    check_eq("bad_no_strobes", 32'((wen_cnt - w0) + (ren_cnt - r0)), 32'd0);
    end_cs();

    // read timeout
    resp_en = 1'b0;
    bif.i_active = 1'b1;
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b0);
    wait_ren("tmo_ren");
    repeat (10) @(negedge clk);
    check_eq("tmo_err_early", 32'(bif.o_err), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("tmo_err", 32'(bif.o_err), 32'd1);
    check_eq("tmo_tx_valid", 32'(bif.o_tx_valid), 32'd0);
    check_eq("tmo_state", 32'(dut.state_q), 32'd6);
    end_cs();

    // CS dropped while the first write strobe is on the bus
    bif.i_active = 1'b1;
    w0 = wen_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h30, 1'b0);
    send_byte(8'hCC, 1'b0);
    bif.i_active = 1'b0;
    @(negedge clk);
    check_eq("abort_state", 32'(dut.state_q), 32'd0);
    check_eq("abort_tx_valid", 32'(bif.o_tx_valid), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("abort_wen_count", 32'(wen_cnt - w0), 32'd1);
    if (wen_cnt > w0) begin
      check_eq("abort_wen_addr", 32'(wen_addr_q[w0]), 32'h30);
      check_eq("abort_wen_data", 32'(wen_data_q[w0]), 32'hCC);
    end
    check_eq("abort_err_kept", 32'(bif.o_err), 32'd1);

    // reset while a read is pending; the late rvalid must be ignored
    resp_en = 1'b1; resp_lat = 8;
    bif.i_active = 1'b1;
    send_byte(8'h02, 1'b1);
    send_byte(8'h40, 1'b0);
    wait_ren("rst_rd_ren");
    r0 = ren_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstrd_outputs", 32'({bif.o_tx_valid, bif.o_bus_wen, bif.o_bus_ren, bif.o_err}), 32'd0);
    check_eq("rstrd_data", 32'({bif.o_tx_data, bif.o_bus_addr, bif.o_bus_wdata}), 32'd0);
    check_eq("rstrd_state", 32'(dut.state_q), 32'd0);
    repeat (12) @(negedge clk);
    check_eq("late_rvalid_tx", 32'(bif.o_tx_valid), 32'd0);
    check_eq("late_rvalid_ren", 32'(ren_cnt - r0), 32'd0);
    check_eq("late_rvalid_state", 32'(dut.state_q), 32'd0);
    check_eq("never_wen_and_ren", 32'(both_cnt), 32'd0);
    check_eq("wen_pulse_max", 32'(wen_run_max), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
